// File: rtl/ysyx_22040127_regfile_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Highest-indexed write port wins collisions; optional same-cycle write-to-read bypass.
module ysyx_22040127_regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRP*AW-1:0]    raddr,
    output logic [NRP*XLEN-1:0]  rdata,
    output logic [NRP-1:0]       rbusy,
    input  logic [NWP-1:0]       wen,
    input  logic [NWP*AW-1:0]    waddr,
    input  logic [NWP*XLEN-1:0]  wdata,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_ready,
    input  logic                 flush,
    output logic [NREG-1:0]      busy_vec,
    output logic [AW:0]          busy_cnt
);

    logic [XLEN-1:0] regs    [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic [NREG-1:0] wr_hit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;

    logic [AW-1:0]   ra [NRP];
    logic [AW-1:0]   wa [NWP];
    logic [XLEN-1:0] wd [NWP];

    for (genvar j = 0; j < NRP; j++) begin : g_ra
        assign ra[j] = raddr[j*AW +: AW];
    end

    for (genvar i = 0; i < NWP; i++) begin : g_wa
        assign wa[i] = waddr[i*AW +: AW];
        assign wd[i] = wdata[i*XLEN +: XLEN];
    end

    // Per-register write decode; later ports override earlier ones, x0 never hits.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            for (int i = 0; i < NWP; i++) begin
                if (wen[i] && (r != 0) && (wa[i] == AW'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = wd[i];
                end
            end
        end
    end

    always_comb begin
        iss_ready = (iss_rd == '0) || !busy[iss_rd] || wr_hit[iss_rd];
        set_vec   = '0;
        if (iss_valid && iss_ready && (iss_rd != '0) && !flush) begin
            set_vec[iss_rd] = 1'b1;
        end
        // Set is applied after clear so a re-claim of a retiring register stays busy.
        if (flush) begin
            busy_next = '0;
        end else begin
            busy_next = (busy & ~wr_hit) | set_vec;
        end
        cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next = cnt_next + (AW + 1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
        end
    end

    assign busy_vec = busy;

    for (genvar j = 0; j < NRP; j++) begin : g_rd
        logic [XLEN-1:0] rd_val;

        always_comb begin
            rd_val = '0;
            if (ra[j] != '0) begin
                rd_val = regs[ra[j]];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWP; i++) begin
                        if (wen[i] && (wa[i] == ra[j])) begin
                            rd_val = wd[i];
                        end
                    end
                end
            end
        end

        assign rdata[j*XLEN +: XLEN] = rd_val;
        assign rbusy[j]              = busy[ra[j]];
    end

endmodule

// File: tb/tb_ysyx_22040127_regfile_sb.sv
// Directed table-driven bench for ysyx_22040127_regfile_sb; a BYPASS=0 copy
// runs in parallel on the same inputs to contrast forwarded and stored reads.
module tb_ysyx_22040127_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int NWP  = 2;
    localparam int AW   = 5;

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [63:0] e_rd0;
        logic [63:0] e_rd0_nb;
        logic [63:0] e_rd1;
        logic        e_ready;
        logic        e_rbusy0;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    logic                clk;
    logic                rst;
    logic [NRP*AW-1:0]   raddr;
    logic [NWP-1:0]      wen;
    logic [NWP*AW-1:0]   waddr;
    logic [NWP*XLEN-1:0] wdata;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;

    logic [NRP*XLEN-1:0] rdata, rdata_nb;
    logic [NRP-1:0]      rbusy, rbusy_nb;
    logic                iss_ready, iss_ready_nb;
    logic [NREG-1:0]     busy_vec, busy_vec_nb;
    logic [AW:0]         busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    ysyx_22040127_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready), .flush(flush),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    ysyx_22040127_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .iss_ready(iss_ready_nb), .flush(flush),
        .busy_vec(busy_vec_nb), .busy_cnt(busy_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic rst_i, input logic [1:0] wen_i,
        input logic [4:0] wa0_i, input logic [63:0] wd0_i,
        input logic [4:0] wa1_i, input logic [63:0] wd1_i,
        input logic [4:0] ra0_i, input logic [4:0] ra1_i,
        input logic iv_i, input logic [4:0] ird_i, input logic fl_i,
        input logic [63:0] e_rd0_i, input logic [63:0] e_rd0_nb_i, input logic [63:0] e_rd1_i,
        input logic e_ready_i, input logic e_rbusy0_i,
        input logic [31:0] e_busy_i, input logic [5:0] e_cnt_i);
        vec_t v;
        v.rst = rst_i;  v.wen = wen_i;
        v.wa0 = wa0_i;  v.wd0 = wd0_i;
        v.wa1 = wa1_i;  v.wd1 = wd1_i;
        v.ra0 = ra0_i;  v.ra1 = ra1_i;
        v.iv  = iv_i;   v.ird = ird_i;  v.fl = fl_i;
        v.e_rd0 = e_rd0_i;  v.e_rd0_nb = e_rd0_nb_i;  v.e_rd1 = e_rd1_i;
        v.e_ready = e_ready_i;  v.e_rbusy0 = e_rbusy0_i;
        v.e_busy = e_busy_i;    v.e_cnt = e_cnt_i;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        wen       = v.wen;
        waddr     = {v.wa1, v.wa0};
        wdata     = {v.wd1, v.wd0};
        raddr     = {v.ra1, v.ra0};
        iss_valid = v.iv;
        iss_rd    = v.ird;
        flush     = v.fl;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Combinational outputs are sampled mid-cycle, registered ones 1ns after the edge.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput({tag, " rdata0"},    rdata[63:0],         v.e_rd0);
        checkOutput({tag, " rdata0_nb"}, rdata_nb[63:0],      v.e_rd0_nb);
        checkOutput({tag, " rdata1"},    rdata[127:64],       v.e_rd1);
        checkOutput({tag, " iss_ready"}, 64'(iss_ready),      64'(v.e_ready));
        checkOutput({tag, " rbusy0"},    64'(rbusy[0]),       64'(v.e_rbusy0));
        @(posedge clk);
        #1;
        checkOutput({tag, " busy_vec"},  64'(busy_vec),       64'(v.e_busy));
        checkOutput({tag, " busy_cnt"},  64'(busy_cnt),       64'(v.e_cnt));
    endtask

    vec_t tbl[$];
    vec_t rst_seq[$];

    initial begin
        rst = 1'b0;  wen = '0;  waddr = '0;  wdata = '0;  raddr = '0;
        iss_valid = 1'b0;  iss_rd = '0;  flush = 1'b0;

        //           rst wen  wa0 wd0            wa1 wd1    ra0 ra1 iv ird fl  e_rd0          e_rd0_nb       e_rd1          rdy rb0 busy          cnt
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  5,  5, 0, 0, 0, 64'h0,        64'h0,        64'h0,        1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b01, 5, 64'hDEAD,     0, 64'h0,  5,  5, 0, 0, 0, 64'hDEAD,     64'h0,        64'hDEAD,     1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  5,  5, 0, 0, 0, 64'hDEAD,     64'hDEAD,     64'hDEAD,     1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b11, 7, 64'h1,        7, 64'h2,  7,  5, 0, 0, 0, 64'h2,        64'h0,        64'hDEAD,     1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  7,  5, 0, 0, 0, 64'h2,        64'h2,        64'hDEAD,     1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  3,  5, 1, 3, 0, 64'h0,        64'h0,        64'hDEAD,     1, 0, 32'h8,        1));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  3,  5, 1, 3, 0, 64'h0,        64'h0,        64'hDEAD,     0, 1, 32'h8,        1));
        tbl.push_back(mkv(1, 2'b10, 0, 64'h0,        3, 64'h33, 3,  5, 1, 3, 0, 64'h33,       64'h0,        64'hDEAD,     1, 1, 32'h8,        1));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  3,  5, 1, 4, 0, 64'h33,       64'h33,       64'hDEAD,     1, 1, 32'h18,       2));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  9,  5, 1, 9, 0, 64'h0,        64'h0,        64'hDEAD,     1, 0, 32'h218,      3));
        tbl.push_back(mkv(1, 2'b01, 0, 64'hFF,       0, 64'h0,  0,  5, 1, 0, 0, 64'h0,        64'h0,        64'hDEAD,     1, 0, 32'h218,      3));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0,  0,  7, 0, 0, 0, 64'h0,        64'h0,        64'h2,        1, 0, 32'h218,      3));
        tbl.push_back(mkv(1, 2'b01, 12, 64'hC0FFEE,  0, 64'h0, 12,  5, 1, 10, 1, 64'hC0FFEE,  64'h0,        64'hDEAD,     1, 0, 32'h0,        0));
        tbl.push_back(mkv(1, 2'b00, 0, 64'h0,        0, 64'h0, 12,  3, 0, 0, 0, 64'hC0FFEE,   64'hC0FFEE,   64'h33,       1, 0, 32'h0,        0));

        // Build five claims with x1 written, then reset for a single edge mid-flight.
        rst_seq.push_back(mkv(1, 2'b01, 1, 64'h55,   0, 64'h0,  1,  5, 1, 1, 0, 64'h55,       64'h0,        64'hDEAD,     1, 0, 32'h2,        1));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0,  1,  5, 1, 2, 0, 64'h55,       64'h55,       64'hDEAD,     1, 1, 32'h6,        2));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0,  1,  5, 1, 3, 0, 64'h55,       64'h55,       64'hDEAD,     1, 1, 32'hE,        3));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0,  1,  5, 1, 4, 0, 64'h55,       64'h55,       64'hDEAD,     1, 1, 32'h1E,       4));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0,  1,  5, 1, 5, 0, 64'h55,       64'h55,       64'hDEAD,     1, 1, 32'h3E,       5));
        rst_seq.push_back(mkv(0, 2'b01, 2, 64'h77,   0, 64'h0,  1,  5, 1, 3, 0, 64'h55,       64'h55,       64'hDEAD,     0, 1, 32'h0,        0));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0,  1,  2, 0, 0, 0, 64'h0,        64'h0,        64'h0,        1, 0, 32'h0,        0));
        rst_seq.push_back(mkv(1, 2'b00, 0, 64'h0,    0, 64'h0, 12,  5, 0, 0, 0, 64'h0,        64'h0,        64'h0,        1, 0, 32'h0,        0));

        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            runVector(tbl[k], $sformatf("v%0d", k));
        end

        for (int k = 0; k < rst_seq.size(); k++) begin
            runVector(rst_seq[k], $sformatf("rst%0d", k));
        end

        $display("[TB] %0d vectors applied", tbl.size() + rst_seq.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_regfile_sb.md
YSYX_22040127_REGFILE_SB -- requirements
Module: ysyx_22040127_regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: register width in bits.
REQ-002 The block SHALL have parameter NREG, default 32: register count, power of two; address width AW = log2(NREG).
REQ-003 The block SHALL have parameter NRP, default 2: number of read ports.
REQ-004 The block SHALL have parameter NWP, default 2: number of write ports.
REQ-005 The block SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to read ports; 0 returns stored data.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-008 The block SHALL have port raddr, input, NRP*AW: read addresses, port i at [i*AW +: AW].
REQ-009 The block SHALL have port rdata, output, NRP*XLEN: read data, port i at [i*XLEN +: XLEN], combinational.
REQ-010 The block SHALL have port rbusy, output, NRP: scoreboard busy bit of each raddr.
REQ-011 The block SHALL have port wen, input, NWP: per-port write enable.
REQ-012 The block SHALL have port waddr, input, NWP*AW: write addresses.
REQ-013 The block SHALL have port wdata, input, NWP*XLEN: write data.
REQ-014 The block SHALL have port iss_valid, input, 1: an issuing instruction claims destination iss_rd.
REQ-015 The block SHALL have port iss_rd, input, AW: destination register of the issuing instruction.
REQ-016 The block SHALL have port iss_ready, output, 1: the claim is accepted this cycle.
REQ-017 The block SHALL have port flush, input, 1: pipeline flush; cancels all outstanding claims.
REQ-018 The block SHALL have port busy_vec, output, NREG: scoreboard state.
REQ-019 The block SHALL have port busy_cnt, output, log2(NREG)+1: number of set busy bits.

Function
REQ-020 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be busy.
REQ-021 A write SHALL occur at a rising edge when wen[i]=1 and waddr[i]!=0, taking effect for reads on the following cycle.
REQ-022 When two or more write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-023 With BYPASS=1, rdata[j] SHALL equal the wdata of the highest-indexed port writing raddr[j] this cycle (raddr[j]!=0); otherwise, and always with BYPASS=0, it SHALL equal the stored value.
REQ-024 A write from port i to register r (r!=0) SHALL clear busy[r] at that edge.
REQ-025 iss_ready SHALL be 1 when iss_rd==0, or busy[iss_rd]==0, or some write port clears iss_rd this cycle; otherwise it SHALL be 0, a WAW stall.
REQ-026 The set condition SHALL be iss_valid & iss_ready & iss_rd!=0 & !flush; when true, busy[iss_rd] SHALL be set at the edge.
REQ-027 Set and clear of the same register in one cycle SHALL leave the register busy (set wins).
REQ-028 flush=1 SHALL clear every busy bit at the edge, override any set in the same cycle, and leave writes of that cycle committed.
REQ-029 rbusy[j] SHALL be busy[raddr[j]] as registered, without same-cycle clear or set forwarding.
REQ-030 busy_cnt SHALL be a registered count updated in the same edge as busy_vec, equal to popcount(busy_vec) at all times, with range 0..NREG-1.

Reset
REQ-031 While rst=0 at an edge, all registers SHALL become 0 and all busy bits SHALL become 0.
REQ-032 While rst=0 at an edge, busy_cnt SHALL become 0 and writes and issues presented in that cycle SHALL be discarded.
REQ-033 After reset, rdata SHALL be 0 for every address, and busy_vec, busy_cnt and rbusy SHALL be 0.
REQ-034 While rst=0, iss_ready SHALL follow its combinational definition; no claim SHALL be recorded.

Verification
REQ-035 The bench SHALL cover write and bypass: wen=01, waddr0=5, wdata0=0xDEAD, raddr0=5 in the same cycle -> rdata0=0xDEAD with BYPASS=1, 0 with BYPASS=0; next cycle rdata0=0xDEAD for both.
REQ-036 The bench SHALL cover a port collision: both ports write x7, port0=0x1 and port1=0x2 -> x7 reads 0x2.
REQ-037 The bench SHALL cover the scoreboard: issue rd=3 -> busy_vec[3]=1 and busy_cnt=1; issue rd=3 again -> iss_ready=0; write x3 with a simultaneous issue rd=3 -> iss_ready=1 and busy[3] stays 1.
REQ-038 The bench SHALL cover flush: busy on x3,x4,x9 with flush=1 and issue rd=10 -> busy_vec=0, busy_cnt=0, and a write in the same cycle is still stored.
REQ-039 The bench SHALL cover x0: write 0xFF to x0 and issue rd=0 -> x0 reads 0, busy_cnt unchanged, iss_ready=1.
REQ-040 The bench SHALL cover reset mid-operation: 5 busy registers and x1=0x55, then rst=0 for one edge -> busy_cnt=0 and x1 reads 0.
